bu_result_collector: RTL and testbench
======================================

# bu_result_collector

Receiving end of the lower butterfly unit's result stream. It captures each `result` word and the four status flags while `data_available` is high, and buffers them in an in-order FIFO. It presents them downstream on a valid/ready handshake. It also issues launch credits to the operand sequencer, so a fixed-latency, non-stallable BU pipeline can never overrun the buffer.

## Interface
Parameters:
- DEPTH, 16: FIFO entries; power of two, at least 4.
- WIDTH, 32: result word width; IEEE-754 single.

Ports:
- clock  in  1  single clock; all logic on the rising edge.
- aclr_n  in  1  asynchronous, active-low reset.
- issue  in  1  sequencer launches an operand pair into the BU this cycle; same pulse as the BU's `data_in_flag`.
- issue_ok  out  1  credit available; the sequencer may assert `issue` only when this is high.
- data_available  in  1  BU result valid this cycle.
- result  in  WIDTH  BU result word.
- zero, overflow, underflow, division_by_zero  in  1 each  BU status flags, sampled with `result`.
- out_valid  out  1  head entry valid.
- out_ready  in  1  downstream accepts the head entry.
- out_data  out  WIDTH  head result word.
- out_flags  out  4  head flags, ordered {division_by_zero, overflow, underflow, zero}.
- fifo_count  out  $clog2(DEPTH)+1  entries currently stored.
- inflight  out  $clog2(DEPTH)+1  issued operand pairs not yet returned.
- err_overissue  out  1  sticky: `issue` was asserted while `issue_ok` was low.
- err_overrun  out  1  sticky: a write was dropped because the FIFO was full.
- err_spurious  out  1  sticky: `data_available` arrived with `inflight` = 0.

## Operation
- Reset (`aclr_n` low, takes effect immediately): pointers, `fifo_count`, `inflight` and all `err_*` go to 0. `out_valid` = 0, `out_data` = 0, `out_flags` = 0. Storage contents are don't-care.
- Credit: `issue_ok` = (`inflight` + `fifo_count`) < DEPTH. It is combinational from registers only, never from `issue` or `data_available`.
- Inflight counter, per cycle:
  - +1 on `issue`; −1 on `data_available`.
  - Both in the same cycle: no change.
  - A decrement at 0 is suppressed and sets `err_spurious`. The word is still written.
  - An increment when `issue_ok` is low is still counted and sets `err_overissue`.
- Write: `data_available` writes {flags, result} at the write pointer; the pointer wraps modulo DEPTH.
- Read: a pop occurs when `out_valid` && `out_ready`; the read pointer wraps modulo DEPTH.
- Push and pop in the same cycle:
  - Both occur; `fifo_count` is unchanged.
  - This holds when full: the write is accepted because a slot frees the same cycle.
  - This holds when empty: it cannot occur, because the head is registered (see Timing).
- Full without a pop: the incoming write is dropped, `err_overrun` is set, and stored data is untouched.
- Ordering: strictly FIFO. The BU's fixed latency guarantees results return in issue order; the collector does no reordering or tagging.
- Flags are stored verbatim; no interpretation.
- Sticky errors clear only on reset.

## Timing
- Write to output: `out_valid` rises on the edge after the `data_available` cycle when the FIFO was empty. That is a 1-cycle bypass latency; the head register loads directly.
- Back-to-back: with `out_ready` held high, one word per cycle leaves with a steady 1-cycle lag. Throughput is 1/cycle.
- Head stability: `out_data` and `out_flags` are stable while `out_valid` && !`out_ready`. The next entry appears on the edge after a pop. If none remains, `out_valid` drops on that edge.
- Credit timing:
  - `issue_ok` changes only after an edge.
  - A pop at full raises `issue_ok` one cycle later.
  - The BU latency (13 cycles) needs no special handling, because credit counts inflight items.
- Reset mid-operation: everything in flight is forgotten. Results arriving after reset are counted as spurious (`err_spurious` set) but still stored. The sequencer must also reset the BU.

## Test plan
- Single op: `issue` at cycle 0, `data_available` with `result`=0x3F800000 at cycle 13 → `out_valid`=1 at cycle 14, `out_data`=0x3F800000, `out_flags`=0; `inflight` returns to 0.
- Credit fill: DEPTH=16, `out_ready`=0, `issue` every cycle → exactly 16 issues with `issue_ok`=1. `issue_ok`=0 from cycle 16 onward. After all returns, `fifo_count`=16; no errors.
- Drain while full: full FIFO, `out_ready`=1 with a concurrent `data_available` → `fifo_count` stays at 16, the new word is last out, `err_overrun`=0.
- Streaming: 100 issues back-to-back with `out_ready`=1, results equal to the index → 100 in-order outputs, one per cycle, `fifo_count` ≤ 2.
- Errors: `data_available` with `inflight`=0 → `err_spurious`=1. `issue` while `issue_ok`=0 → `err_overissue`=1. A forced write at full with no pop → `err_overrun`=1, and head data is unchanged.
- Async reset: assert `aclr_n` low mid-stream, between clock edges → all outputs are 0 immediately and remain 0 until the first write after release.

Source files
------------

// File: rtl/bu_result_collector.sv
// bu_result_collector: in-order result buffer behind the lower butterfly unit.
// It captures {flags, result} on data_available and presents the oldest entry
// through a registered head on a valid/ready handshake. It also hands out
// launch credits, so the fixed-latency BU can never overrun the buffer.
module bu_result_collector #(
  parameter int DEPTH = 16,
  parameter int WIDTH = 32
) (
  input  logic                     clock,
  input  logic                     aclr_n,
  input  logic                     issue,
  output logic                     issue_ok,
  input  logic                     data_available,
  input  logic [WIDTH-1:0]         result,
  input  logic                     zero,
  input  logic                     overflow,
  input  logic                     underflow,
  input  logic                     division_by_zero,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [WIDTH-1:0]         out_data,
  output logic [3:0]               out_flags,
  output logic [$clog2(DEPTH):0]   fifo_count,
  output logic [$clog2(DEPTH):0]   inflight,
  output logic                     err_overissue,
  output logic                     err_overrun,
  output logic                     err_spurious
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam int EW = WIDTH + 4;
  localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

  // Storage holds every buffered entry, including the one mirrored in the head.
  logic [EW-1:0] mem_q [DEPTH];

  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [AW-1:0] rd_next;
  logic [CW-1:0] count_q, count_d;
  logic [CW-1:0] inflight_q, inflight_d;
  logic          out_valid_q, out_valid_d;
  logic [EW-1:0] head_q, head_d;
  logic          err_overissue_q, err_overissue_d;
  logic          err_overrun_q, err_overrun_d;
  logic          err_spurious_q, err_spurious_d;

  logic          full;
  logic          pop;
  logic          push;
  logic [EW-1:0] wdata;
  logic [CW:0]   credit_sum;

  assign wdata      = {division_by_zero, overflow, underflow, zero, result};
  assign full       = (count_q == FULL_CNT);
  assign pop        = out_valid_q & out_ready;
  // A full buffer still takes a word when a slot frees in the same cycle.
  assign push       = data_available & (~full | pop);
  assign rd_next    = rd_ptr_q + AW'(1);

  // Credits count both stored words and words still inside the BU pipeline.
  assign credit_sum = {1'b0, inflight_q} + {1'b0, count_q};
  assign issue_ok   = (credit_sum < (CW+1)'(DEPTH));

  // Next-state for pointers, occupancy, head register, credit counter and errors.
  always_comb begin
    wr_ptr_d        = push ? wr_ptr_q + AW'(1) : wr_ptr_q;
    rd_ptr_d        = pop  ? rd_next           : rd_ptr_q;

    count_d = count_q;
    case ({push, pop})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase

    // Head: next stored entry after a pop, or the incoming word when it
    // becomes the oldest one (buffer empty, or only the popped entry left).
    out_valid_d = out_valid_q;
    head_d      = head_q;
    if (pop) begin
      if (count_q > CW'(1)) begin
        head_d      = mem_q[rd_next];
        out_valid_d = 1'b1;
      end else if (push) begin
        head_d      = wdata;
        out_valid_d = 1'b1;
      end else begin
        out_valid_d = 1'b0;
      end
    end else if (push && !out_valid_q) begin
      head_d      = wdata;
      out_valid_d = 1'b1;
    end

    inflight_d      = inflight_q;
    err_spurious_d  = err_spurious_q;
    err_overissue_d = err_overissue_q | (issue & ~issue_ok);
    err_overrun_d   = err_overrun_q | (data_available & ~push);
    if (issue && !data_available) begin
      if (inflight_q != '1) inflight_d = inflight_q + CW'(1);
    end else if (data_available && !issue) begin
      if (inflight_q == '0) err_spurious_d = 1'b1;
      else                  inflight_d     = inflight_q - CW'(1);
    end
  end

  // Control state and the registered head, cleared asynchronously.
  always_ff @(posedge clock or negedge aclr_n) begin
    if (!aclr_n) begin
      wr_ptr_q        <= '0;
      rd_ptr_q        <= '0;
      count_q         <= '0;
      inflight_q      <= '0;
      out_valid_q     <= 1'b0;
      head_q          <= '0;
      err_overissue_q <= 1'b0;
      err_overrun_q   <= 1'b0;
      err_spurious_q  <= 1'b0;
    end else begin
      wr_ptr_q        <= wr_ptr_d;
      rd_ptr_q        <= rd_ptr_d;
      count_q         <= count_d;
      inflight_q      <= inflight_d;
      out_valid_q     <= out_valid_d;
      head_q          <= head_d;
      err_overissue_q <= err_overissue_d;
      err_overrun_q   <= err_overrun_d;
      err_spurious_q  <= err_spurious_d;
    end
  end

  // Buffer storage; contents need no reset.
  always_ff @(posedge clock) begin
    if (push) mem_q[wr_ptr_q] <= wdata;
  end

  assign out_valid     = out_valid_q;
  assign out_data      = head_q[WIDTH-1:0];
  assign out_flags     = head_q[EW-1:WIDTH];
  assign fifo_count    = count_q;
  assign inflight      = inflight_q;
  assign err_overissue = err_overissue_q;
  assign err_overrun   = err_overrun_q;
  assign err_spurious  = err_spurious_q;

endmodule

// File: tb/tb_bu_result_collector.sv
// Bench for bu_result_collector: a queue-based model of the buffer and credit
// rules, a 13-cycle BU emulation, per-cycle comparison, and directed scenarios.
module tb_bu_result_collector;

  localparam int DEPTH = 16;
  localparam int WIDTH = 32;
  localparam int LAT   = 13;

  logic        clock = 1'b0;
  logic        aclr_n = 1'b0;
  logic        issue = 1'b0;
  logic        issue_ok;
  logic        data_available;
  logic [31:0] result;
  logic        zero, overflow, underflow, division_by_zero;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [31:0] out_data;
  logic [3:0]  out_flags;
  logic [4:0]  fifo_count;
  logic [4:0]  inflight;
  logic        err_overissue, err_overrun, err_spurious;

  always #5 clock = ~clock;

  bu_result_collector #(.DEPTH(DEPTH), .WIDTH(WIDTH)) dut (
    .clock(clock), .aclr_n(aclr_n), .issue(issue), .issue_ok(issue_ok),
    .data_available(data_available), .result(result), .zero(zero),
    .overflow(overflow), .underflow(underflow),
    .division_by_zero(division_by_zero), .out_valid(out_valid),
    .out_ready(out_ready), .out_data(out_data), .out_flags(out_flags),
    .fifo_count(fifo_count), .inflight(inflight),
    .err_overissue(err_overissue), .err_overrun(err_overrun),
    .err_spurious(err_spurious)
  );

  // ---------------- BU emulation plus a forced-write override ----------------
  typedef struct packed {int due; logic [31:0] d; logic [3:0] f;} bu_t;
  bu_t         bu_q[$];
  bu_t         bu_e;
  logic [31:0] iss_val = '0;
  logic [3:0]  iss_fl = '0;
  logic        bu_da = 1'b0, f_da = 1'b0;
  logic [31:0] bu_res = '0, f_res = '0;
  logic [3:0]  bu_fl = '0, f_fl = '0;
  int          pc = 0;

  assign data_available = bu_da | f_da;
  assign result         = f_da ? f_res : bu_res;
  assign {division_by_zero, overflow, underflow, zero} = f_da ? f_fl : bu_fl;

  always @(posedge clock) begin
    pc++;
    if (issue) begin
      bu_e.due = pc + LAT; bu_e.d = iss_val; bu_e.f = iss_fl;
      bu_q.push_back(bu_e);
    end
  end

  always @(negedge clock) begin
    bu_da = 1'b0;
    if (bu_q.size() > 0 && bu_q[0].due == pc + 1) begin
      bu_da = 1'b1; bu_res = bu_q[0].d; bu_fl = bu_q[0].f;
      void'(bu_q.pop_front());
    end
  end

  // ---------------- behavioural model ----------------
  logic [35:0] mq[$];
  int          m_infl = 0;
  bit          m_eo = 0, m_er = 0, m_es = 0;
  bit          m_pop, m_ok;
  int          m_cyc = 0;
  int          pop_cnt = 0, first_pop = 0, last_pop = 0;
  logic [35:0] last_word = '0;

  always @(posedge clock or negedge aclr_n) begin
    if (!aclr_n) begin
      mq.delete(); m_infl = 0; m_eo = 0; m_er = 0; m_es = 0;
    end else begin
      m_cyc++;
      m_pop = (mq.size() > 0) && out_ready;
      m_ok  = (m_infl + mq.size()) < DEPTH;
      if (issue && !m_ok) m_eo = 1;
      if (issue && !data_available) m_infl++;
      else if (data_available && !issue) begin
        if (m_infl == 0) m_es = 1; else m_infl--;
      end
      if (m_pop) begin
        last_word = mq.pop_front();
        pop_cnt++;
        if (pop_cnt == 1) first_pop = m_cyc;
        last_pop = m_cyc;
      end
      if (data_available) begin
        if (mq.size() < DEPTH) mq.push_back({division_by_zero, overflow, underflow, zero, result});
        else m_er = 1;
      end
    end
  end

  // ---------------- checking ----------------
  int n_cmp = 0, n_err = 0;
  bit chk_en = 0;
  int max_fc = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  always @(negedge clock) begin
    if (aclr_n && chk_en) begin
      if (int'(fifo_count) > max_fc) max_fc = int'(fifo_count);
      chk("out_valid", out_valid, mq.size() != 0);
      if (mq.size() != 0) begin
        chk("out_data", out_data, mq[0][31:0]);
        chk("out_flags", out_flags, mq[0][35:32]);
      end
      chk("fifo_count", fifo_count, mq.size());
      chk("inflight", inflight, m_infl);
      chk("issue_ok", issue_ok, (m_infl + mq.size()) < DEPTH);
      chk("err_overissue", err_overissue, m_eo);
      chk("err_overrun", err_overrun, m_er);
      chk("err_spurious", err_spurious, m_es);
    end
  end

  task automatic do_reset();
    @(negedge clock); aclr_n = 1'b0; issue = 1'b0; f_da = 1'b0; out_ready = 1'b0;
    @(negedge clock); aclr_n = 1'b1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  int t0, n_iss, first_block, p0;
  bit seen;

  initial begin
    // reset values
    #1;
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_data", out_data, 0);
    chk("rst_fifo_count", fifo_count, 0);
    chk("rst_inflight", inflight, 0);
    chk("rst_issue_ok", issue_ok, 1);
    @(negedge clock); aclr_n = 1'b1; chk_en = 1;

    // single op: result visible in the cycle after the data_available cycle
    @(negedge clock); issue = 1'b1; iss_val = 32'h3F800000; iss_fl = 4'h0;
    @(negedge clock); issue = 1'b0; t0 = pc;
    seen = 0;
    for (int i = 0; i < 30 && !seen; i++) begin
      @(negedge clock);
      if (out_valid) seen = 1;
    end
    chk("single_seen", seen, 1);
    chk("single_latency_edges", pc - t0, 13);
    chk("single_data", out_data, 32'h3F800000);
    chk("single_flags", out_flags, 4'h0);
    chk("single_inflight", inflight, 0);
    out_ready = 1'b1;
    @(negedge clock); out_ready = 1'b0;
    chk("single_drained", fifo_count, 0);

    // credit fill with no draining
    n_iss = 0; first_block = -1;
    for (int i = 0; i < 40; i++) begin
      @(negedge clock);
      issue = issue_ok; iss_val = 32'h100 + i; iss_fl = 4'(i);
      if (issue_ok) n_iss++;
      else if (first_block < 0) first_block = i;
    end
    issue = 1'b0;
    repeat (20) @(negedge clock);
    chk("fill_issues", n_iss, 16);
    chk("fill_first_block", first_block, 16);
    chk("fill_count", fifo_count, 16);
    chk("fill_issue_ok", issue_ok, 0);
    chk("fill_no_err", {err_overissue, err_overrun, err_spurious}, 3'b000);

    // drain while full with a concurrent write
    out_ready = 1'b1; f_da = 1'b1; f_res = 32'hDEAD0001; f_fl = 4'hA;
    @(negedge clock); f_da = 1'b0; out_ready = 1'b0;
    chk("full_pushpop_count", fifo_count, 16);
    chk("full_pushpop_overrun", err_overrun, 0);
    p0 = pop_cnt; out_ready = 1'b1;
    for (int i = 0; i < 40 && fifo_count != 0; i++) @(negedge clock);
    out_ready = 1'b0;
    chk("drain_pops", pop_cnt - p0, 16);
    chk("drain_last_word", last_word, {4'hA, 32'hDEAD0001});

    // streaming: 100 back-to-back issues, always ready
    do_reset();
    pop_cnt = 0; max_fc = 0; out_ready = 1'b1;
    for (int i = 0; i < 100; i++) begin
      @(negedge clock); issue = 1'b1; iss_val = i; iss_fl = 4'(i % 16);
    end
    @(negedge clock); issue = 1'b0;
    for (int i = 0; i < 40 && pop_cnt < 100; i++) @(negedge clock);
    chk("stream_pops", pop_cnt, 100);
    chk("stream_last", last_word, {4'(99 % 16), 32'd99});
    chk("stream_one_per_cycle", last_pop - first_pop, 99);
    chk("stream_max_count_le2", max_fc <= 2, 1);
    out_ready = 1'b0;

    // error scenarios
    do_reset();
    @(negedge clock); f_da = 1'b1; f_res = 32'h0BAD0000; f_fl = 4'h5;
    @(negedge clock); f_da = 1'b0;
    chk("spurious_set", err_spurious, 1);
    chk("spurious_stored", fifo_count, 1);
    chk("spurious_inflight", inflight, 0);
    for (int i = 0; i < 17; i++) begin
      @(negedge clock); issue = 1'b1; iss_val = 32'h200 + i; iss_fl = 4'h3;
    end
    @(negedge clock); issue = 1'b0;
    chk("overissue_set", err_overissue, 1);
    repeat (30) @(negedge clock);
    chk("overrun_set", err_overrun, 1);
    chk("overrun_count", fifo_count, 16);
    chk("overrun_head_data", out_data, 32'h0BAD0000);
    chk("overrun_head_flags", out_flags, 4'h5);

    // asynchronous reset between edges, mid-stream
    for (int i = 0; i < 5; i++) begin
      @(negedge clock); issue = 1'b1; iss_val = 32'h300 + i; iss_fl = 4'h1;
    end
    @(negedge clock); issue = 1'b0;
    @(negedge clock);
    #2 aclr_n = 1'b0;
    #1;
    chk("arst_valid", out_valid, 0);
    chk("arst_data", out_data, 0);
    chk("arst_flags", out_flags, 0);
    chk("arst_count", fifo_count, 0);
    chk("arst_inflight", inflight, 0);
    chk("arst_errs", {err_overissue, err_overrun, err_spurious}, 3'b000);
    @(negedge clock); aclr_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clock);
      chk("arst_hold_valid", out_valid, 0);
      chk("arst_hold_data", out_data, 0);
    end
    repeat (20) @(negedge clock);
    chk("arst_late_spurious", err_spurious, 1);
    chk("arst_late_count", fifo_count, 5);
    chk("arst_late_head", out_data, 32'h300);
    chk("arst_late_overissue", err_overissue, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
